// File: rtl/output_sram_writer_pkg.sv
// rtl/output_sram_writer_pkg.sv - shared types and constants for the output SRAM writer
package output_sram_writer_pkg;

    localparam int NUM_BANKS   = 4;
    localparam int FV_size     = 8;
    localparam int MAX_FV_num  = 16;
    localparam int Max_Node_id = 256;

    localparam int WORD_W         = 2 * FV_size;
    localparam int WORDS_PER_NODE = MAX_FV_num / 2;
    localparam int NID_W          = $clog2(Max_Node_id);
    localparam int ADDR_W         = $clog2(Max_Node_id * WORDS_PER_NODE);
    localparam int BANK_W         = $clog2(NUM_BANKS);
    localparam int WCNT_W         = $clog2(WORDS_PER_NODE + 1);

    typedef struct packed {
        logic              req;
        logic              Grant_valid;
        logic              sos;
        logic              eos;
        logic [WORD_W-1:0] data;
        logic [NID_W-1:0]  Node_id;
    } Bank_Req2Req_Output_SRAM;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        STREAM
    } writer_state_e;

    function automatic logic [ADDR_W-1:0] node_addr(input logic [NID_W-1:0] nid,
                                                   input logic [WCNT_W-1:0] cnt);
        return ADDR_W'(nid) * ADDR_W'(WORDS_PER_NODE) + ADDR_W'(cnt);
    endfunction

endpackage

// File: rtl/output_sram_writer_if.sv
// rtl/output_sram_writer_if.sv - bank request/stream inputs and SRAM write/status outputs
interface output_sram_writer_if;
    import output_sram_writer_pkg::*;

    Bank_Req2Req_Output_SRAM [NUM_BANKS-1:0] bank_pkt;
    logic [NUM_BANKS-1:0] req_grant;
    logic                 sram_wen;
    logic [ADDR_W-1:0]    sram_addr;
    logic [WORD_W-1:0]    sram_wdata;
    logic                 node_done;
    logic [NID_W-1:0]     done_node_id;
    logic                 busy;
    logic                 overflow;

    modport master (
        output bank_pkt,
        input  req_grant, sram_wen, sram_addr, sram_wdata,
        input  node_done, done_node_id, busy, overflow
    );

    modport slave (
        input  bank_pkt,
        output req_grant, sram_wen, sram_addr, sram_wdata,
        output node_done, done_node_id, busy, overflow
    );

endinterface

// File: rtl/output_sram_writer_rr_arbiter.sv
// rtl/output_sram_writer_rr_arbiter.sv - combinational round-robin pick starting at ptr_i
module output_sram_writer_rr_arbiter
    import output_sram_writer_pkg::*;
(
    input  logic [NUM_BANKS-1:0] req_i,
    input  logic [BANK_W-1:0]    ptr_i,
    output logic [NUM_BANKS-1:0] grant_o,
    output logic [BANK_W-1:0]    idx_o,
    output logic                 valid_o
);

    logic [BANK_W:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            cand = {1'b0, ptr_i} + (BANK_W+1)'(k);
            if (cand >= (BANK_W+1)'(NUM_BANKS)) begin
                cand = cand - (BANK_W+1)'(NUM_BANKS);
            end
            if (!valid_o && req_i[cand[BANK_W-1:0]]) begin
                valid_o                   = 1'b1;
                idx_o                     = cand[BANK_W-1:0];
                grant_o[cand[BANK_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_sram_writer.sv
// rtl/output_sram_writer.sv - arbitrates accumulation banks and writes node vectors to the output SRAM
module output_sram_writer
    import output_sram_writer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output_sram_writer_if.slave wr_if
);

    writer_state_e        state_q;
    logic [BANK_W-1:0]    winner_q, rr_ptr_q;
    logic [WCNT_W-1:0]    word_cnt_q;
    logic [NID_W-1:0]     node_id_q, pend_id_q, done_id_q;
    logic [NUM_BANKS-1:0] req_grant_q;
    logic                 wen_q, done_pend_q, node_done_q, busy_q, overflow_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [WORD_W-1:0]    wdata_q;

    logic [NUM_BANKS-1:0] req_vec, arb_grant;
    logic [BANK_W-1:0]    arb_idx, next_ptr;
    logic                 arb_valid;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            req_vec[i] = wr_if.bank_pkt[i].req;
        end
    end

    output_sram_writer_rr_arbiter u_arb (
        .req_i   (req_vec),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Only the registered winner's lanes are ever looked at, so stray beats never reach the datapath.
    logic              beat_gv, beat_sos, beat_eos, room;
    logic [WORD_W-1:0] beat_data;
    logic [NID_W-1:0]  beat_nid, eff_nid;
    logic [WCNT_W-1:0] eff_cnt;

    assign beat_gv   = wr_if.bank_pkt[winner_q].Grant_valid;
    assign beat_sos  = wr_if.bank_pkt[winner_q].sos;
    assign beat_eos  = wr_if.bank_pkt[winner_q].eos;
    assign beat_data = wr_if.bank_pkt[winner_q].data;
    assign beat_nid  = wr_if.bank_pkt[winner_q].Node_id;
    assign eff_cnt   = beat_sos ? '0 : word_cnt_q;
    assign eff_nid   = beat_sos ? beat_nid : node_id_q;
    assign room      = eff_cnt < WCNT_W'(WORDS_PER_NODE);
    assign next_ptr  = (winner_q == BANK_W'(NUM_BANKS - 1)) ? '0 : winner_q + BANK_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            winner_q    <= '0;
            rr_ptr_q    <= '0;
            word_cnt_q  <= '0;
            node_id_q   <= '0;
            pend_id_q   <= '0;
            done_id_q   <= '0;
            req_grant_q <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            done_pend_q <= 1'b0;
            node_done_q <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            req_grant_q <= '0;
            wen_q       <= 1'b0;
            done_pend_q <= 1'b0;
            node_done_q <= done_pend_q;
            if (done_pend_q) begin
                done_id_q <= pend_id_q;
            end
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        winner_q    <= arb_idx;
                        req_grant_q <= arb_grant;
                        state_q     <= GRANT;
                        busy_q      <= 1'b1;
                    end
                end
                // The first beat arrives alongside req_grant, so GRANT captures exactly like STREAM.
                GRANT, STREAM: begin
                    state_q <= STREAM;
                    if (beat_gv) begin
                        node_id_q <= eff_nid;
                        if (room) begin
                            wen_q      <= 1'b1;
                            addr_q     <= node_addr(eff_nid, eff_cnt);
                            wdata_q    <= beat_data;
                            word_cnt_q <= eff_cnt + WCNT_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                            word_cnt_q <= eff_cnt;
                        end
                        if (beat_eos) begin
                            done_pend_q <= 1'b1;
                            pend_id_q   <= eff_nid;
                            word_cnt_q  <= '0;
                            rr_ptr_q    <= next_ptr;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_if.req_grant    = req_grant_q;
    assign wr_if.sram_wen     = wen_q;
    assign wr_if.sram_addr    = addr_q;
    assign wr_if.sram_wdata   = wdata_q;
    assign wr_if.node_done    = node_done_q;
    assign wr_if.done_node_id = done_id_q;
    assign wr_if.busy         = busy_q;
    assign wr_if.overflow     = overflow_q;

endmodule
